// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and op-class helper for alu_mc.
package alu_pkg;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_OR    = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_NOR   = 4'b0101;
   localparam logic [3:0] ALU_SLTU  = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_SLL   = 4'b1000;
   localparam logic [3:0] ALU_SRL   = 4'b1001;
   localparam logic [3:0] ALU_SRA   = 4'b1010;
   localparam logic [3:0] ALU_RSVD  = 4'b1011;
   localparam logic [3:0] ALU_MUL   = 4'b1100;
   localparam logic [3:0] ALU_MULHU = 4'b1101;
   localparam logic [3:0] ALU_DIVU  = 4'b1110;
   localparam logic [3:0] ALU_REMU  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   // MUL/MULHU/DIVU/REMU all live in the 11xx opcode quadrant
   function automatic logic is_iterative(input logic [3:0] op);
      return (op[3:2] == 2'b11);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring divide, one step per cycle, WIDTH steps.
// hi/lo hold {product high, product low} for multiply and
// {remainder, quotient} for divide, so one register pair serves both.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic             sel_hi,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   import alu_pkg::*;

   localparam int CNTW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic             div_q, div_d, sel_q, sel_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   logic [WIDTH:0]   add_sum, shl, diff;
   logic [WIDTH-1:0] step_hi, step_lo;

   // One datapath step: shift-add for multiply, compare/subtract for divide
   always_comb begin
      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shl     = {hi_q, lo_q[WIDTH-1]};
      diff    = shl - {1'b0, b_q};
      if (div_q) begin
         // remainder stays below the divisor, so diff[WIDTH] is a clean borrow
         if (!diff[WIDTH]) begin
            step_hi = diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = shl[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi = add_sum[WIDTH:1];
         step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Load on start, then step while the counter is non-zero; the last step
   // is presented combinationally so the top can register it directly
   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      b_d   = b_q;
      div_d = div_q;
      sel_d = sel_q;
      cnt_d = cnt_q;
      done  = 1'b0;
      if (start) begin
         hi_d  = '0;
         lo_d  = opa;
         b_d   = opb;
         div_d = is_div;
         sel_d = sel_hi;
         cnt_d = CNTW'(WIDTH);
      end else if (cnt_q != '0) begin
         hi_d  = step_hi;
         lo_d  = step_lo;
         cnt_d = cnt_q - CNTW'(1);
         done  = (cnt_q == CNTW'(1));
      end
      result = sel_q ? step_hi : step_lo;
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         sel_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
         div_q <= div_d;
         sel_q <= sel_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with valid/ready in and out. Single-cycle ops are
// computed at accept; 11xx ops run through alu_muldiv_iter.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   input  logic [3:0]       aluoperation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             lt,
   output logic             gt,
   output logic             div_zero
);
   import alu_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, lt_q, lt_d, gt_q, gt_d, dz_q, dz_d;

   logic             accept, iter_op, div_by_zero, md_start, md_done;
   logic [WIDTH-1:0] md_result, alu_res;
   logic [SHW-1:0]   shamt;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign lt        = lt_q;
   assign gt        = gt_q;
   assign div_zero  = dz_q;

   assign accept      = in_valid && in_ready;
   assign iter_op     = is_iterative(aluoperation);
   assign div_by_zero = iter_op && aluoperation[1] && (data2 == '0);
   assign md_start    = accept && iter_op && !div_by_zero;
   assign shamt       = data2[SHW-1:0];

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .is_div (aluoperation[1]),
      .sel_hi (aluoperation[0]),
      .opa    (data1),
      .opb    (data2),
      .done   (md_done),
      .result (md_result)
   );

   // Single-cycle results; DIVU/REMU entries are the divide-by-zero answers
   always_comb begin
      alu_res = '0;
      case (aluoperation)
         ALU_ADD, ALU_RSVD: alu_res = data1 + data2;
         ALU_SUB:   alu_res = data1 - data2;
         ALU_AND:   alu_res = data1 & data2;
         ALU_OR:    alu_res = data1 | data2;
         ALU_XOR:   alu_res = data1 ^ data2;
         ALU_NOR:   alu_res = ~(data1 | data2);
         ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
         ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
         ALU_SLL:   alu_res = data1 << shamt;
         ALU_SRL:   alu_res = data1 >> shamt;
         ALU_SRA:   alu_res = $unsigned($signed(data1) >>> shamt);
         ALU_DIVU:  alu_res = '1;
         ALU_REMU:  alu_res = data1;
         default:   alu_res = '0;
      endcase
   end

   // FSM next state and registered outputs
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      lt_d     = lt_q;
      gt_d     = gt_q;
      dz_d     = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               lt_d = (data1 < data2);
               gt_d = (data1 > data2);
               dz_d = div_by_zero;
               if (md_start) begin
                  state_d = ST_BUSY;
               end else begin
                  state_d  = ST_DONE;
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
               end
            end
         end
         ST_BUSY: begin
            if (md_done) begin
               state_d  = ST_DONE;
               result_d = md_result;
               zero_d   = (md_result == '0);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any op in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         lt_q     <= 1'b0;
         gt_q     <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         lt_q     <= lt_d;
         gt_q     <= gt_d;
         dz_q     <= dz_d;
      end
   end

endmodule
